// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches 32-bit words over a req/ack
// instruction-memory port, latches them into IR and selects the next PC when
// the current instruction is accepted downstream.
//
// state | meaning
// IDLE  | after reset; no request outstanding, IR not valid
// FETCH | imem_req high at address pc, waiting for imem_ack
// VALID | IR holds the instruction at pc; held while stall is high
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch,
  input  logic            jmp,
  input  logic            zero,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic [5:0]      op,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [15:0]     count_q;
  logic            req_q;
  logic            valid_q;

  // Next-PC select; the branch offset wraps modulo 2^PC_W, so a large low
  // field acts as a negative displacement without explicit sign extension.
  always_comb begin
    next_pc = pc_q + PC_W'(1);
    if (jmp) begin
      next_pc = ir[PC_W-1:0];
    end else if (branch && zero) begin
      next_pc = pc_q + PC_W'(1) + ir[PC_W-1:0];
    end
  end

  // Fetch FSM with registered handshake/valid outputs, PC, IR and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      ir      <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        FETCH: begin
          if (imem_ack) begin
            ir      <= imem_rdata;
            state   <= VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (!stall) begin
            pc_q    <= next_pc;
            state   <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm         = ir[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// instruction stream, checked against a PC/count model derived from the
// fetch-stage rules with plain integer arithmetic.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jmp = 1'b0;
  logic        zero = 1'b0;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;
  int exp_count = 0;
  logic [31:0] exp_ir = '0;

  instr_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch(branch), .jmp(jmp), .zero(zero), .instr_valid(instr_valid),
    .pc(pc), .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC: jump target, or pc+1 plus a signed 8-bit offset, mod 256.
  function automatic int model_next(input int cur, input logic [31:0] word,
                                    input logic br, input logic jp, input logic z);
    int off;
    int lo;
    lo  = int'(word[7:0]);
    off = (lo >= 128) ? lo - 256 : lo;
    if (jp) return lo;
    if (br && z) return (((cur + 1 + off) % 256) + 256) % 256;
    return (cur + 1) % 256;
  endfunction

  task automatic fetch_one(input logic [31:0] data, input int lat);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_timeout: imem_req=%b want 1", imem_req);
    end
    checks++;
    if (imem_addr !== 8'(exp_pc)) begin
      errors++;
      $display("FAIL fetch_addr: got %h want %h", imem_addr, 8'(exp_pc));
    end
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      branch = 1'($urandom); jmp = 1'($urandom); zero = 1'($urandom);
      stall = 1'($urandom);
      step();
      checks++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 8'(exp_pc)}) begin
        errors++;
        $display("FAIL fetch_wait: req/valid/addr got %b/%b/%h want 1/0/%h",
                 imem_req, instr_valid, imem_addr, 8'(exp_pc));
      end
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    exp_ir = data;
    checks++;
    if ({instr_valid, imem_req} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_valid: valid/req got %b/%b want 1/0", instr_valid, imem_req);
    end
    checks++;
    if (pc !== 8'(exp_pc)) begin
      errors++;
      $display("FAIL fetch_pc: got %h want %h", pc, 8'(exp_pc));
    end
    checks++;
    if ({op, rs, rt, imm} !== data || {rd, funct} !== {data[15:11], data[5:0]}) begin
      errors++;
      $display("FAIL fetch_fields: op=%h rs=%h rt=%h rd=%h funct=%h imm=%h want ir=%h",
               op, rs, rt, rd, funct, imm, data);
    end
  endtask

  task automatic accept_one(input logic br, input logic jp, input logic z, input int stalls);
    stall = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      branch = 1'($urandom); jmp = 1'($urandom); zero = 1'($urandom);
      step();
      checks++;
      if ({instr_valid, imem_req, pc, instr_count} !== {1'b1, 1'b0, 8'(exp_pc), 16'(exp_count)}
          || {op, rs, rt, imm} !== exp_ir) begin
        errors++;
        $display("FAIL stall_hold: valid=%b req=%b pc=%h cnt=%0d ir=%h want 1/0/%h/%0d/%h",
                 instr_valid, imem_req, pc, instr_count, {op, rs, rt, imm},
                 8'(exp_pc), exp_count, exp_ir);
      end
    end
    stall = 1'b0;
    branch = br; jmp = jp; zero = z;
    step();
    branch = 1'b0; jmp = 1'b0; zero = 1'b0;
    exp_pc = model_next(exp_pc, exp_ir, br, jp, z);
    if (exp_count < 65535) exp_count++;
    checks++;
    if ({instr_valid, imem_req} !== 2'b01) begin
      errors++;
      $display("FAIL accept_state: valid/req got %b/%b want 0/1", instr_valid, imem_req);
    end
    checks++;
    if (imem_addr !== 8'(exp_pc)) begin
      errors++;
      $display("FAIL accept_next_pc: got %h want %h", imem_addr, 8'(exp_pc));
    end
    checks++;
    if (instr_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL accept_count: got %0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({imem_req, instr_valid, pc, op, rs, rt, rd, funct, imm, instr_count} !== '0) begin
      errors++;
      $display("FAIL %s: req=%b valid=%b pc=%h op=%h rs=%h rt=%h rd=%h funct=%h imm=%h cnt=%0d want all 0",
               tag, imem_req, instr_valid, pc, op, rs, rt, rd, funct, imm, instr_count);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    check_reset_outputs("reset_initial");
    rst = 1'b0;
    exp_pc = 0; exp_count = 0;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_req: got %b want 0", imem_req);
    end
    step();
    checks++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_req: req/addr/valid got %b/%h/%b want 1/00/0",
               imem_req, imem_addr, instr_valid);
    end
    fetch_one(32'hFC00_1234, 1);
    accept_one(1'b0, 1'b0, 1'b0, 0);
    fetch_one(32'hABCD_EF01, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_midrun_async");
    step();
    rst = 1'b0;
    exp_pc = 0; exp_count = 0;
    step();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset_restart: req/addr got %b/%h want 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      fetch_one(w, (k == 0) ? 0 : (k == 1) ? 3 : 1);
      checks++;
      if (op !== w[31:26] || pc !== 8'(k)) begin
        errors++;
        $display("FAIL seq_op_pc: op=%h pc=%h want %h/%h", op, pc, w[31:26], 8'(k));
      end
      accept_one(1'b0, 1'b0, 1'b0, 0);
    end
    checks++;
    if (instr_count !== 16'd3) begin
      errors++;
      $display("FAIL seq_count: got %0d want 3", instr_count);
    end
  endtask

  task automatic test_jump();
    fetch_one(32'h0800_0040, 2);
    accept_one(1'b1, 1'b1, 1'b1, 0);
    checks++;
    if (imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL jump_target: got %h want 40", imem_addr);
    end
  endtask

  task automatic test_branch();
    fetch_one(32'h0800_0010, 0);
    accept_one(1'b0, 1'b1, 1'b0, 0);
    fetch_one(32'h1000_FFFC, 1);
    accept_one(1'b1, 1'b0, 1'b1, 0);
    checks++;
    if (imem_addr !== 8'h0D) begin
      errors++;
      $display("FAIL branch_taken: got %h want 0d", imem_addr);
    end
    fetch_one(32'h0800_0010, 0);
    accept_one(1'b0, 1'b1, 1'b0, 0);
    fetch_one(32'h1000_FFFC, 0);
    accept_one(1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (imem_addr !== 8'h11) begin
      errors++;
      $display("FAIL branch_not_taken: got %h want 11", imem_addr);
    end
  endtask

  task automatic test_stall_wrap();
    fetch_one($urandom, 2);
    accept_one(1'b0, 1'b0, 1'b0, 4);
    fetch_one(32'h0800_00FF, 0);
    accept_one(1'b0, 1'b1, 1'b0, 1);
    fetch_one({6'h00, 10'h000, 16'h0005}, 1);
    accept_one(1'b0, 1'b0, 1'b1, 0);
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_pc: got %h want 00", imem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    step();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rmf_pending: req got %b want 1", imem_req);
    end
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({imem_req, instr_valid, pc} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rmf_req_drop: req/valid/pc got %b/%b/%h want 0/0/00",
               imem_req, instr_valid, pc);
    end
    step();
    rst = 1'b0;
    exp_pc = 0; exp_count = 0;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({instr_valid, imem_req, imem_addr, op} !== {1'b0, 1'b1, 8'h00, 6'h00}) begin
      errors++;
      $display("FAIL rmf_stale_ack: valid/req/addr/op got %b/%b/%h/%h want 0/1/00/00",
               instr_valid, imem_req, imem_addr, op);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmf_still_fetch: valid got %b want 0", instr_valid);
    end
    fetch_one(32'h2222_3333, 0);
    accept_one(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic br, jp, z;
    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      fetch_one(w, $urandom_range(0, 3));
      br = 1'($urandom);
      jp = ($urandom_range(0, 3) == 0);
      z  = 1'($urandom);
      accept_one(br, jp, z, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
